// File: rtl/memristor_booth_pkg.sv
// Shared types and constants for the radix-2 Booth multiplier.
// Holds the FSM state type and the Booth pair codes for {Q0, Q(-1)}.
package memristor_booth_pkg;

  typedef enum logic [1:0] {
    StIdle = 2'b00,
    StRun  = 2'b01,
    StDone = 2'b10
  } state_e;

  localparam logic [1:0] BoothNop0 = 2'b00;
  localparam logic [1:0] BoothAdd  = 2'b01;
  localparam logic [1:0] BoothSub  = 2'b10;
  localparam logic [1:0] BoothNop1 = 2'b11;

endpackage

// File: rtl/memristor_booth_step.sv
// One radix-2 Booth step: conditional add/subtract of M into A, then an
// arithmetic right shift of {A, Q, Q(-1)} by one position.
module memristor_booth_step
  import memristor_booth_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic [WIDTH:0] a_i,
  input  logic [WIDTH:0] q_i,
  input  logic           qm1_i,
  input  logic [WIDTH:0] m_i,
  output logic [WIDTH:0] a_o,
  output logic [WIDTH:0] q_o,
  output logic           qm1_o
);

  logic [WIDTH+1:0] a_ext;
  logic [WIDTH+1:0] m_ext;
  logic [WIDTH+1:0] sum;

  // One guard bit above the WIDTH+1 register keeps A +/- M exact for every operand.
  always_comb begin
    a_ext = {a_i[WIDTH], a_i};
    m_ext = {m_i[WIDTH], m_i};
    sum   = a_ext;
    unique case ({q_i[0], qm1_i})
      BoothNop0: sum = a_ext;
      BoothAdd:  sum = a_ext + m_ext;
      BoothSub:  sum = a_ext - m_ext;
      BoothNop1: sum = a_ext;
    endcase
    a_o   = sum[WIDTH+1:1];
    q_o   = {sum[0], q_i[WIDTH:1]};
    qm1_o = q_i[0];
  end

endmodule

// File: rtl/memristor_booth_mul_n.sv
// Sequential radix-2 Booth multiplier, signed or unsigned WIDTH-bit operands.
// The top level owns the FSM, iteration counter and all state registers.
module memristor_booth_mul_n
  import memristor_booth_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic                 signed_mode,
  input  logic [WIDTH-1:0]     multiplicand,
  input  logic [WIDTH-1:0]     multiplier,
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH-1:0]   product
);

  localparam int unsigned ITER_S = WIDTH;
  localparam int unsigned ITER_U = WIDTH + 1;
  localparam int unsigned CntW   = $clog2(ITER_U + 1);

  state_e             state_q;
  logic [CntW-1:0]    cnt_q;
  logic [WIDTH:0]     a_q;
  logic [WIDTH:0]     q_q;
  logic [WIDTH:0]     m_q;
  logic               qm1_q;
  logic               mode_q;
  logic               busy_q;
  logic               done_q;
  logic [2*WIDTH-1:0] product_q;

  logic [WIDTH:0]     a_nxt;
  logic [WIDTH:0]     q_nxt;
  logic               qm1_nxt;
  logic [2*WIDTH-1:0] product_nxt;
  logic               ext_m;
  logic               ext_q;

  assign ext_m = signed_mode & multiplicand[WIDTH-1];
  assign ext_q = signed_mode & multiplier[WIDTH-1];

  memristor_booth_step #(
    .WIDTH (WIDTH)
  ) u_step (
    .a_i   (a_q),
    .q_i   (q_q),
    .qm1_i (qm1_q),
    .m_i   (m_q),
    .a_o   (a_nxt),
    .q_o   (q_nxt),
    .qm1_o (qm1_nxt)
  );

  // Signed mode runs one step fewer, so its product sits one bit higher in {A,Q}.
  always_comb begin
    if (mode_q) begin
      product_nxt = {a_nxt[WIDTH-1:0], q_nxt[WIDTH:1]};
    end else begin
      product_nxt = {a_nxt[WIDTH-2:0], q_nxt};
    end
  end

  // busy/done are registered from the state, so they trail it by one cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      a_q       <= '0;
      q_q       <= '0;
      m_q       <= '0;
      qm1_q     <= 1'b0;
      mode_q    <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      product_q <= '0;
    end else begin
      busy_q <= (state_q == StRun);
      done_q <= (state_q == StDone);
      unique case (state_q)
        StIdle: begin
          if (start) begin
            a_q     <= '0;
            q_q     <= {ext_q, multiplier};
            m_q     <= {ext_m, multiplicand};
            qm1_q   <= 1'b0;
            mode_q  <= signed_mode;
            cnt_q   <= signed_mode ? CntW'(ITER_S) : CntW'(ITER_U);
            state_q <= StRun;
          end
        end
        StRun: begin
          a_q   <= a_nxt;
          q_q   <= q_nxt;
          qm1_q <= qm1_nxt;
          cnt_q <= cnt_q - CntW'(1);
          if (cnt_q == CntW'(1)) begin
            product_q <= product_nxt;
            state_q   <= StDone;
          end
        end
        StDone: begin
          state_q <= StIdle;
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

  assign busy    = busy_q;
  assign done    = done_q;
  assign product = product_q;

endmodule

// File: tb/tb_memristor_booth_mul_n.sv
// Bench for memristor_booth_mul_n: WIDTH=8 and WIDTH=4 instances, a cycle-timeline
// model with reference multiply checked every cycle, plus directed literal checks.
module tb_memristor_booth_mul_n;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic       st8 = 1'b0, sm8 = 1'b0;
  logic [7:0] m8 = '0, q8 = '0;
  logic       busy8, done8;
  logic [15:0] p8;

  logic       st4 = 1'b0, sm4 = 1'b0;
  logic [3:0] m4 = '0, q4 = '0;
  logic       busy4, done4;
  logic [7:0] p4;

  memristor_booth_mul_n #(.WIDTH(8)) u_dut8 (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (st8),
    .signed_mode  (sm8),
    .multiplicand (m8),
    .multiplier   (q8),
    .busy         (busy8),
    .done         (done8),
    .product      (p8)
  );

  memristor_booth_mul_n #(.WIDTH(4)) u_dut4 (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (st4),
    .signed_mode  (sm4),
    .multiplicand (m4),
    .multiplier   (q4),
    .busy         (busy4),
    .done         (done4),
    .product      (p4)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference product: plain integer multiply, truncated to 2*w bits.
  function automatic logic [31:0] ref_mul(input int w, input bit sm,
                                          input logic [15:0] m, input logic [15:0] q);
    longint mask, mv, qv, pv;
    mask = (longint'(1) << w) - 1;
    mv = longint'(m) & mask;
    qv = longint'(q) & mask;
    if (sm && m[w-1]) mv = mv - (longint'(1) << w);
    if (sm && q[w-1]) qv = qv - (longint'(1) << w);
    pv = (mv * qv) & ((longint'(1) << (2 * w)) - 1);
    return 32'(pv);
  endfunction

  // Timeline model: t counts edges since acceptance; iter is the Booth step count.
  typedef struct packed {
    bit          act;
    int          t;
    int          iter;
    logic [31:0] pend;
    logic [31:0] prod;
  } mdl_t;

  function automatic mdl_t step_mdl(input mdl_t s, input bit st, input bit sm,
                                    input logic [15:0] m, input logic [15:0] q, input int w);
    mdl_t n = s;
    if (st && (!s.act || s.t == s.iter + 1)) begin
      n.act  = 1'b1;
      n.t    = 0;
      n.iter = sm ? w : w + 1;
      n.pend = ref_mul(w, sm, m, q);
    end else if (s.act) begin
      n.t = s.t + 1;
      if (n.t == s.iter) n.prod = s.pend;
      if (n.t > s.iter + 1) n.act = 1'b0;
    end
    return n;
  endfunction

  function automatic bit e_busy(input mdl_t s);
    return s.act && s.t >= 1 && s.t <= s.iter;
  endfunction

  function automatic bit e_done(input mdl_t s);
    return s.act && s.t == s.iter + 1;
  endfunction

  mdl_t md8, md4;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      md8 <= '0;
      md4 <= '0;
    end else begin
      md8 <= step_mdl(md8, st8, sm8, 16'(m8), 16'(q8), 8);
      md4 <= step_mdl(md4, st4, sm4, 16'(m4), 16'(q4), 4);
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      check("busy8", 32'(busy8), 32'(e_busy(md8)));
      check("done8", 32'(done8), 32'(e_done(md8)));
      check("prod8", 32'(p8), md8.prod);
      check("busy_done_excl8", 32'(busy8 & done8), 32'd0);
      check("busy4", 32'(busy4), 32'(e_busy(md4)));
      check("done4", 32'(done4), 32'(e_done(md4)));
      check("prod4", 32'(p4), md4.prod);
      check("busy_done_excl4", 32'(busy4 & done4), 32'd0);
    end
  end

  // One transaction; operands are scrambled while it runs. lat = edges from accept to done.
  task automatic op(input int w, input bit sm, input logic [15:0] m, input logic [15:0] q,
                    output logic [15:0] p, output int lat, output int nbusy);
    bit b, d;
    lat = -1;
    nbusy = 0;
    p = '0;
    @(posedge clk);
    #1;
    if (w == 8) begin st8 = 1'b1; sm8 = sm; m8 = m[7:0]; q8 = q[7:0]; end
    else        begin st4 = 1'b1; sm4 = sm; m4 = m[3:0]; q4 = q[3:0]; end
    @(posedge clk);
    #1;
    st8 = 1'b0;
    st4 = 1'b0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      b = (w == 8) ? busy8 : busy4;
      d = (w == 8) ? done8 : done4;
      if (b) nbusy++;
      if (d) begin
        lat = k;
        p = (w == 8) ? p8 : 16'(p4);
        break;
      end
      if (w == 8) begin m8 = 8'($urandom); q8 = 8'($urandom); sm8 = 1'($urandom); end
      else        begin m4 = 4'($urandom); q4 = 4'($urandom); sm4 = 1'($urandom); end
    end
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
    $fatal(1);
  end

  initial begin
    logic [15:0] p;
    int lat, nb, ndone, d1, d2, w;
    bit sm;
    logic [15:0] rm, rq;

    repeat (3) @(posedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
    check("reset_busy8", 32'(busy8), 32'd0);
    check("reset_done8", 32'(done8), 32'd0);
    check("reset_prod8", 32'(p8), 32'd0);
    check("reset_prod4", 32'(p4), 32'd0);

    op(8, 1'b1, 16'h0003, 16'h00FB, p, lat, nb);
    check("s8_3x-5_prod", 32'(p), 32'h0000_FFF1);
    check("s8_3x-5_lat", 32'(lat), 32'd9);
    check("s8_3x-5_busy", 32'(nb), 32'd8);

    op(8, 1'b1, 16'h0080, 16'h0080, p, lat, nb);
    check("s8_min_x_min_prod", 32'(p), 32'h0000_4000);
    check("s8_min_x_min_lat", 32'(lat), 32'd9);

    op(8, 1'b0, 16'h00FF, 16'h00FF, p, lat, nb);
    check("u8_ff_x_ff_prod", 32'(p), 32'h0000_FE01);
    check("u8_ff_x_ff_lat", 32'(lat), 32'd10);
    check("u8_ff_x_ff_busy", 32'(nb), 32'd9);

    op(4, 1'b1, 16'h0007, 16'h0008, p, lat, nb);
    check("s4_7x-8_prod", 32'(p), 32'h0000_00C8);
    check("s4_7x-8_lat", 32'(lat), 32'd5);

    op(4, 1'b0, 16'h000F, 16'h000F, p, lat, nb);
    check("u4_f_x_f_prod", 32'(p), 32'h0000_00E1);
    check("u4_f_x_f_lat", 32'(lat), 32'd6);

    // Second start three cycles into RUN must be dropped.
    @(posedge clk);
    #1 st8 = 1'b1; sm8 = 1'b1; m8 = 8'd12; q8 = 8'd10;
    @(posedge clk);
    #1 st8 = 1'b0;
    repeat (3) @(posedge clk);
    #1 st8 = 1'b1; m8 = 8'd99; q8 = 8'd77;
    @(posedge clk);
    #1 st8 = 1'b0;
    ndone = 0;
    p = '0;
    for (int k = 0; k < 25; k++) begin
      @(negedge clk);
      if (done8) begin ndone++; p = p8; end
    end
    check("ignored_start_ndone", 32'(ndone), 32'd1);
    check("ignored_start_prod", 32'(p), 32'h0000_0078);

    // Asynchronous reset between edges while running.
    @(posedge clk);
    #1 st8 = 1'b1; sm8 = 1'b0; m8 = 8'd200; q8 = 8'd3;
    @(posedge clk);
    #1 st8 = 1'b0;
    repeat (3) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    check("async_rst_busy8", 32'(busy8), 32'd0);
    check("async_rst_done8", 32'(done8), 32'd0);
    check("async_rst_prod8", 32'(p8), 32'd0);
    #3 rst_n = 1'b1;
    op(8, 1'b0, 16'd200, 16'd3, p, lat, nb);
    check("after_rst_prod", 32'(p), 32'h0000_0258);
    check("after_rst_lat", 32'(lat), 32'd10);

    // start held high: back-to-back operations ITER+2 edges apart.
    @(posedge clk);
    #1 st8 = 1'b1; sm8 = 1'b1; m8 = 8'hF9; q8 = 8'd6;
    d1 = -1;
    d2 = -1;
    p = '0;
    for (int k = 0; k < 40 && d2 < 0; k++) begin
      @(negedge clk);
      if (done8) begin
        if (d1 < 0) d1 = cyc;
        else        d2 = cyc;
        p = p8;
      end
    end
    st8 = 1'b0;
    check("b2b_spacing", 32'(d2 - d1), 32'd10);
    check("b2b_prod", 32'(p), 32'h0000_FFD6);
    repeat (14) @(posedge clk);

    for (int i = 0; i < 300; i++) begin
      w  = (i % 2 == 0) ? 8 : 4;
      sm = 1'($urandom);
      rm = 16'($urandom);
      rq = 16'($urandom);
      if (i < 8) begin
        rm = (i % 4 < 2) ? 16'hFFFF : 16'h0000;
        rq = (i % 4 == 1 || i % 4 == 2) ? 16'h8000 >> (16 - w) : 16'hFFFF;
      end
      op(w, sm, rm, rq, p, lat, nb);
      check("rand_prod", 32'(p), ref_mul(w, sm, rm, rq));
      check("rand_lat", 32'(lat), 32'(sm ? w + 1 : w + 2));
      check("rand_busy", 32'(nb), 32'(sm ? w : w + 1));
      repeat ($urandom_range(0, 2)) @(posedge clk);
    end

    repeat (3) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
